// File: rtl/psg_wrq_pkg.sv
// Shared types for the PSG write sequencer: FSM states, FIFO entry layout, reset constants.
// PSG_WRQ_GG_STEREO_EN selects whether the entry tag bit is stored in the FIFO.
package psg_wrq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH
    } psg_wrq_state_e;

    localparam logic TAG_PSG = 1'b0;
    localparam logic TAG_GG  = 1'b1;

    typedef struct packed {
        logic       tag;
        logic [7:0] data;
    } psg_wrq_entry_t;

    localparam logic [7:0] PSG_MUX_RST = 8'hFF;

endpackage

// File: rtl/psg_wrq_fifo.sv
// Synchronous FIFO with registered pointers carrying one extra wrap bit.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module psg_wrq_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

    // Pointers differ only in the wrap bit when the FIFO is full.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign level = wr_ptr_q - rd_ptr_q;
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/psg_wr_queue.sv
// Buffers CPU PSG/stereo writes and replays them as clean psg_wr_n strobes.
// Define PSG_WRQ_GG_STEREO_EN to queue Game Gear stereo writes alongside PSG writes.
module psg_wr_queue
    import psg_wrq_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned LOW_CYC  = 2,
    parameter int unsigned HIGH_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_psg_we,
    input  logic                   cpu_gg_we,
    input  logic [7:0]             cpu_din,
    output logic                   psg_wr_n,
    output logic [7:0]             psg_din,
    output logic [7:0]             psg_mux,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

`ifdef PSG_WRQ_GG_STEREO_EN
    localparam int unsigned FW = 9;
`else
    localparam int unsigned FW = 8;
`endif
    localparam int unsigned CMAX = (LOW_CYC > HIGH_CYC) ? LOW_CYC : HIGH_CYC;
    localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    psg_wrq_state_e state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     din_q, din_d;
    logic [7:0]     mux_q, mux_d;
    logic           wr_n_q, wr_n_d;
    logic           ovf_q, ovf_d;

    logic           fifo_push, fifo_pop, both_we;
    logic [FW-1:0]  fifo_din, fifo_dout;
    psg_wrq_entry_t head;

`ifdef PSG_WRQ_GG_STEREO_EN
    always_comb begin
        fifo_push = cpu_psg_we | cpu_gg_we;
        both_we   = cpu_psg_we & cpu_gg_we;
        fifo_din  = cpu_psg_we ? {TAG_PSG, cpu_din} : {TAG_GG, cpu_din};
        head      = fifo_dout;
    end
`else
    logic gg_we_unused;
    assign gg_we_unused = cpu_gg_we;

    always_comb begin
        fifo_push = cpu_psg_we;
        both_we   = 1'b0;
        fifo_din  = cpu_din;
        head      = {TAG_PSG, fifo_dout};
    end
`endif

    psg_wrq_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        din_d    = din_q;
        mux_d    = mux_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    fifo_pop = 1'b1;
                    // Stereo bytes bypass the strobe sequence so they stay cheap but ordered.
                    if (head.tag == TAG_GG) begin
                        mux_d = head.data;
                    end else begin
                        din_d   = head.data;
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = LOW;
            end
            LOW: begin
                if (cnt_q == CW'(LOW_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = HIGH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HIGH: begin
                if (cnt_q == CW'(HIGH_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        ovf_d  = ovf_q | both_we | (fifo_push & full & ~fifo_pop);
        wr_n_d = (state_d != LOW);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            din_q   <= 8'h00;
            mux_q   <= PSG_MUX_RST;
            wr_n_q  <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            mux_q   <= mux_d;
            wr_n_q  <= wr_n_d;
            ovf_q   <= ovf_d;
        end
    end

    assign psg_wr_n = wr_n_q;
    assign psg_din  = din_q;
    assign psg_mux  = mux_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_psg_wr_queue.sv
// Directed bench for psg_wr_queue: cycle-exact vector table plus multi-cycle sequences.
module tb_psg_wr_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_psg_we, cpu_gg_we;
    logic [7:0] cpu_din;
    logic       psg_wr_n;
    logic [7:0] psg_din, psg_mux;
    logic       full, empty, overflow;
    logic [3:0] level;

    psg_wr_queue #(.DEPTH(8), .LOW_CYC(2), .HIGH_CYC(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_psg_we (cpu_psg_we),
        .cpu_gg_we  (cpu_gg_we),
        .cpu_din    (cpu_din),
        .psg_wr_n   (psg_wr_n),
        .psg_din    (psg_din),
        .psg_mux    (psg_mux),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe log: data and mux captured at each falling edge of psg_wr_n.
    logic [7:0] log_din[$];
    logic [7:0] log_mux[$];
    int         log_cyc[$];

    always @(negedge psg_wr_n) begin
        #1;
        log_din.push_back(psg_din);
        log_mux.push_back(psg_mux);
        log_cyc.push_back(cyc);
    end

    typedef struct {
        logic       we;
        logic [7:0] din;
        logic       exp_wr_n;
        logic [7:0] exp_din;
        logic [3:0] exp_level;
        logic       exp_empty;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        cpu_psg_we = 1'b0;
        cpu_gg_we  = 1'b0;
        cpu_din    = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        log_din.delete();
        log_mux.delete();
        log_cyc.delete();
    endtask

    task automatic push_psg(input logic [7:0] b);
        cpu_psg_we = 1'b1;
        cpu_din    = b;
        @(negedge clk);
        cpu_psg_we = 1'b0;
    endtask

    task automatic push_gg(input logic [7:0] b);
        cpu_gg_we = 1'b1;
        cpu_din   = b;
        @(negedge clk);
        cpu_gg_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] latch;
        logic [9:0] tone0;
        logic [3:0] vol0;
        logic [7:0] exp_b;

        // Push at row 0 and again at row 6 (last HIGH cycle) to prove IDLE is reached at N+7.
        tbl[0]  = '{1'b1, 8'h8F, 1'b1, 8'h00, 4'd0, 1'b1};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 8'h00, 4'd1, 1'b0};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 8'h8F, 4'd0, 1'b1};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 8'h8F, 4'd0, 1'b1};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 8'h8F, 4'd0, 1'b1};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 8'h8F, 4'd0, 1'b1};
        tbl[6]  = '{1'b1, 8'h42, 1'b1, 8'h8F, 4'd0, 1'b1};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 8'h8F, 4'd1, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 8'h42, 4'd0, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'h42, 4'd0, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 8'h42, 4'd0, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 8'h42, 4'd0, 1'b1};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 8'h42, 4'd0, 1'b1};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 8'h42, 4'd0, 1'b1};

        do_reset();
        chk("rst_wr_n",  32'(psg_wr_n), 32'h1);
        chk("rst_din",   32'(psg_din),  32'h00);
        chk("rst_mux",   32'(psg_mux),  32'hFF);
        chk("rst_empty", 32'(empty),    32'h1);
        chk("rst_full",  32'(full),     32'h0);
        chk("rst_level", 32'(level),    32'h0);
        chk("rst_ovf",   32'(overflow), 32'h0);

        for (int i = 0; i < 14; i++) begin
            chk($sformatf("vec%0d", i),
                32'({psg_wr_n, psg_din, level, empty, full, overflow, psg_mux}),
                32'({tbl[i].exp_wr_n, tbl[i].exp_din, tbl[i].exp_level, tbl[i].exp_empty,
                     1'b0, 1'b0, 8'hFF}));
            cpu_psg_we = tbl[i].we;
            cpu_din    = tbl[i].din;
            @(negedge clk);
        end
        cpu_psg_we = 1'b0;

        // Back-to-back writes through a jt89-style register model.
        do_reset();
        push_psg(8'h80);
        push_psg(8'h3F);
        push_psg(8'h9A);
        repeat (40) @(negedge clk);
        chk("seq3_count", 32'(log_din.size()), 32'd3);
        chk("seq3_b0", 32'(log_din[0]), 32'h80);
        chk("seq3_b1", 32'(log_din[1]), 32'h3F);
        chk("seq3_b2", 32'(log_din[2]), 32'h9A);
        chk("seq3_gap01", 32'(log_cyc[1] - log_cyc[0]), 32'd6);
        chk("seq3_gap12", 32'(log_cyc[2] - log_cyc[1]), 32'd6);
        latch = 3'd0;
        tone0 = '0;
        vol0  = '0;
        for (int i = 0; i < log_din.size(); i++) begin
            if (log_din[i][7]) begin
                latch = log_din[i][6:4];
                if (latch == 3'd0) tone0[3:0] = log_din[i][3:0];
                else if (latch == 3'd1) vol0 = log_din[i][3:0];
            end else if (latch == 3'd0) begin
                tone0[9:4] = log_din[i][5:0];
            end
        end
        chk("jt89_tone0", 32'(tone0), 32'h3F0);
        chk("jt89_vol0",  32'(vol0),  32'hA);

        // Fill to full with the pop stalled; 11th push dropped, push at c14 rides on a pop.
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            if (k == 10) begin
                chk("ovf_lvl9",  32'(level),    32'd7);
                chk("ovf_flag9", 32'(overflow), 32'h0);
            end
            if (k == 11) begin
                chk("ovf_lvl10",  32'(level),    32'd8);
                chk("ovf_full10", 32'(full),     32'h1);
                chk("ovf_flag10", 32'(overflow), 32'h0);
            end
            if (k == 12) begin
                chk("ovf_lvl11",  32'(level),    32'd8);
                chk("ovf_flag11", 32'(overflow), 32'h1);
            end
            if (k == 15) begin
                chk("pushpop_lvl",  32'(level), 32'd8);
                chk("pushpop_full", 32'(full),  32'h1);
            end
            cpu_psg_we = (k <= 11) || (k == 14);
            cpu_din    = (k == 14) ? 8'h77 : 8'(16 + k);
            @(negedge clk);
        end
        cpu_psg_we = 1'b0;
        repeat (80) @(negedge clk);
        chk("ovf_sticky", 32'(overflow), 32'h1);
        chk("ovf_drained", 32'(empty), 32'h1);
        chk("ovf_count", 32'(log_din.size()), 32'd11);
        for (int i = 0; i < 11; i++) begin
            exp_b = (i < 10) ? 8'(8'h11 + i) : 8'h77;
            chk($sformatf("ovf_data%0d", i), 32'(log_din[i]), 32'(exp_b));
        end

        // Simultaneous strobes: PSG byte wins; GG-only push depends on the build.
        do_reset();
        cpu_psg_we = 1'b1;
        cpu_gg_we  = 1'b1;
        cpu_din    = 8'h55;
        @(negedge clk);
        cpu_psg_we = 1'b0;
        cpu_gg_we  = 1'b0;
        repeat (10) @(negedge clk);
        chk("both_count", 32'(log_din.size()), 32'd1);
        chk("both_data",  32'(log_din[0]), 32'h55);
        chk("both_mux",   32'(psg_mux), 32'hFF);
`ifdef PSG_WRQ_GG_STEREO_EN
        chk("both_ovf", 32'(overflow), 32'h1);
`else
        chk("both_ovf", 32'(overflow), 32'h0);
`endif
        do_reset();
        push_gg(8'h0F);
        repeat (4) @(negedge clk);
        chk("gg_only_strobes", 32'(log_din.size()), 32'd0);
        chk("gg_only_ovf", 32'(overflow), 32'h0);
`ifdef PSG_WRQ_GG_STEREO_EN
        chk("gg_only_mux", 32'(psg_mux), 32'h0F);
`else
        chk("gg_only_mux", 32'(psg_mux), 32'hFF);
`endif

`ifdef PSG_WRQ_GG_STEREO_EN
        do_reset();
        push_psg(8'h9F);
        push_gg(8'h0F);
        push_psg(8'hBF);
        repeat (30) @(negedge clk);
        chk("st_count", 32'(log_din.size()), 32'd2);
        chk("st_d0",    32'(log_din[0]), 32'h9F);
        chk("st_d1",    32'(log_din[1]), 32'hBF);
        chk("st_mux0",  32'(log_mux[0]), 32'hFF);
        chk("st_mux1",  32'(log_mux[1]), 32'h0F);
        chk("st_gap",   32'(log_cyc[1] - log_cyc[0]), 32'd7);
`endif

        // Reset in the middle of a low pulse flushes the queue.
        do_reset();
        push_psg(8'hA1);
        push_psg(8'hA2);
        push_psg(8'hA3);
        push_psg(8'hA4);
        for (int i = 0; i < 20 && psg_wr_n; i++) @(negedge clk);
        chk("rst_mid_low", 32'(psg_wr_n), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_wr_n",  32'(psg_wr_n), 32'h1);
        chk("rst_mid_level", 32'(level),    32'd0);
        chk("rst_mid_empty", 32'(empty),    32'h1);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("rst_mid_strobes", 32'(log_din.size()), 32'd1);
        chk("rst_mid_idle",    32'(psg_wr_n), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
